mmio_uart_tx: RTL



---
 rtl/mmio_uart_tx.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx
//   Memory-mapped 8N1 UART transmitter sitting on the core's data-memory bus.
//   Store bytes written to TXDATA go into a TX FIFO. A framing FSM drains the
//   FIFO onto `tx`, with no idle gap between back-to-back frames. STATUS is
//   returned on the combinational read path, so single-cycle loads keep their
//   timing.
//
//   Register map (a[3:2]):
//     0 TXDATA  write pushes wd[7:0]; reads 0
//     1 STATUS  {16'b0, count[7:0], 4'b0, ovf, busy, empty, full};
//               writing wd[3]=1 clears ovf
//     2,3       reads 0, writes ignored
//
//   Optional build macro: UART_TX_PARITY_EN. When it is defined, an even-parity
//   bit is inserted between the data bits and the stop bit (8E1, 11*C frame).
//
// Ports:
//   clk  in   system clock, rising edge
//   rst  in   synchronous active-high reset
//   we   in   store strobe
//   a    in   [31:0] byte address
//   wd   in   [31:0] store data
//   rd   out  [31:0] combinational read data, 0 when not selected
//   hit  out  combinational window decode
//   tx   out  registered serial output, idles high
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
  parameter int          CLKS_PER_BIT = 16,
  parameter int          FIFO_DEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        hit,
  output logic        tx
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  // Bus decode
  logic sel_txdata, sel_status, wr_txdata, push, pop, ovf_set, ovf_clr;
  logic full, empty, busy;

  // FIFO
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [7:0]       head;
  logic             ovf_reg;

  // Framing FSM
  state_t          state_reg, state_next;
  logic [BAUD_W-1:0] baud_reg, baud_next;
  logic [2:0]      bit_reg, bit_next;
  logic [7:0]      shift_reg, shift_next;
  logic            tx_reg, tx_next;
  logic            bit_done;
`ifdef UART_TX_PARITY_EN
  logic            parity_reg, parity_next;
`endif

  // Address bits below the word and data bits above the byte carry no meaning.
  logic unused_bits;
  assign unused_bits = ^{a[1:0], wd[31:8]};

  assign hit        = (a[31:4] == BASE_ADDR[31:4]);
  assign sel_txdata = hit && (a[3:2] == 2'd0);
  assign sel_status = hit && (a[3:2] == 2'd1);

  assign full  = (count_reg == CNT_FULL);
  assign empty = (count_reg == '0);
  assign busy  = (state_reg != S_IDLE);

  // Full is judged on the registered count, so a same-edge pop cannot
  // make room for the push.
  assign wr_txdata = we && sel_txdata;
  assign push      = wr_txdata && !full;
  assign ovf_set   = wr_txdata && full;
  assign ovf_clr   = we && sel_status && wd[3];

  assign head = mem[rd_ptr_reg];

  always_comb begin
    rd = '0;
    if (sel_status)
      rd = {16'd0, 8'(count_reg), 4'd0, ovf_reg, busy, empty, full};
  end

  // FIFO storage: no reset, only the pointers and count define contents.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= wd[7:0];
  end

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
      // Set has priority over clear.
      if (ovf_set)
        ovf_reg <= 1'b1;
      else if (ovf_clr)
        ovf_reg <= 1'b0;
    end
  end

  assign bit_done = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next = state_reg;
    baud_next  = baud_reg;
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = tx_reg;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_next = parity_reg;
`endif
    if (state_reg != S_IDLE)
      baud_next = bit_done ? '0 : baud_reg + BAUD_W'(1);

    case (state_reg)
      S_IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          state_next = S_START;
          shift_next = head;
          tx_next    = 1'b0;
          baud_next  = '0;
          bit_next   = '0;
`ifdef UART_TX_PARITY_EN
          parity_next = ^head;
`endif
        end
      end
      S_START: begin
        if (bit_done) begin
          state_next = S_DATA;
          tx_next    = shift_reg[0];
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = S_PARITY;
            tx_next    = parity_reg;
`else
            state_next = S_STOP;
            tx_next    = 1'b1;
`endif
          end else begin
            // Drive the next bit straight from the unshifted register.
            bit_next   = bit_reg + 3'd1;
            shift_next = shift_reg >> 1;
            tx_next    = shift_reg[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_done) begin
          state_next = S_STOP;
          tx_next    = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (!empty) begin
            // Chain straight into the next start bit.
            pop        = 1'b1;
            state_next = S_START;
            shift_next = head;
            tx_next    = 1'b0;
            bit_next   = '0;
`ifdef UART_TX_PARITY_EN
            parity_next = ^head;
`endif
          end else begin
            state_next = S_IDLE;
            tx_next    = 1'b1;
          end
        end
      end
      default: begin
        state_next = S_IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      baud_reg   <= '0;
      bit_reg    <= '0;
      shift_reg  <= '0;
      tx_reg     <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_reg <= 1'b0;
`endif
    end else begin
      state_reg  <= state_next;
      baud_reg   <= baud_next;
      bit_reg    <= bit_next;
      shift_reg  <= shift_next;
      tx_reg     <= tx_next;
`ifdef UART_TX_PARITY_EN
      parity_reg <= parity_next;
`endif
    end
  end

  assign tx = tx_reg;

endmodule
